// File: rtl/jtkunio_rom_pkg.sv
// Shared types and constants for the Kunio graphics ROM server:
// FSM states, slot identifiers and default SDRAM region bases.
package jtkunio_rom_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [1:0] SLOT_CHAR = 2'd0;
    localparam logic [1:0] SLOT_SCR  = 2'd1;
    localparam logic [1:0] SLOT_OBJ  = 2'd2;

    localparam int          DEF_AW          = 22;
    localparam logic [21:0] DEF_CHAR_OFFSET = 22'h00000;
    localparam logic [21:0] DEF_SCR_OFFSET  = 22'h04000;
    localparam logic [21:0] DEF_OBJ_OFFSET  = 22'h24000;

    // Widest port address; the transaction register is sized to hold any of them.
    localparam int TADDR_W = 18;

endpackage

// File: rtl/jtkunio_rom_slot.sv
// One cached ROM word for a single video port: valid flag, tag address and data,
// with hit/miss evaluation against the port's live address.
module jtkunio_rom_slot
    import jtkunio_rom_pkg::*;
#(
    parameter int SW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [SW-1:0] addr_i,
    input  logic          we_i,
    input  logic [SW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   data_o,
    output logic          ok_o,
    output logic          miss_o
);

    logic          valid_q;
    logic [SW-1:0] caddr_q;
    logic [31:0]   cdata_q;
    logic          hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            caddr_q <= '0;
            cdata_q <= '0;
        end else if (we_i) begin
            valid_q <= 1'b1;
            caddr_q <= waddr_i;
            cdata_q <= wdata_i;
        end
    end

    // A disabled port neither reports ok nor asks for service.
    assign hit    = valid_q && (addr_i == caddr_q);
    assign ok_o   = en_i && hit;
    assign miss_o = en_i && !hit;
    assign data_o = cdata_q;

endmodule

// File: rtl/jtkunio_rom_server.sv
// Serves the char, scroll and object graphics ROM ports from one SDRAM read bus,
// keeping one cached word per port and refilling misses with fixed priority.
module jtkunio_rom_server
    import jtkunio_rom_pkg::*;
#(
    parameter int            AW          = DEF_AW,
    parameter logic [AW-1:0] CHAR_OFFSET = AW'(DEF_CHAR_OFFSET),
    parameter logic [AW-1:0] SCR_OFFSET  = AW'(DEF_SCR_OFFSET),
    parameter logic [AW-1:0] OBJ_OFFSET  = AW'(DEF_OBJ_OFFSET)
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [13:0]   char_addr,
    output logic [31:0]   char_data,
    output logic          char_ok,

    input  logic [16:0]   scr_addr,
    output logic [31:0]   scr_data,
    output logic          scr_ok,

    input  logic          obj_cs,
    input  logic [17:0]   obj_addr,
    output logic [31:0]   obj_data,
    output logic          obj_ok,

    output logic [AW-1:0] sdram_addr,
    output logic          sdram_req,
    input  logic          sdram_ack,
    input  logic          sdram_rdy,
    input  logic [31:0]   sdram_dout
);

    state_e               st_q;
    logic [1:0]           id_q;
    logic [TADDR_W-1:0]   taddr_q;
    logic [AW-1:0]        sdram_addr_q;
    logic                 req_q;

    logic                 char_miss, scr_miss, obj_miss;
    logic [1:0]           win_id;
    logic [TADDR_W-1:0]   win_taddr;
    logic [AW-1:0]        win_saddr;
    logic                 done;
    logic                 we_char, we_scr, we_obj;

    // Fixed priority char > scr > obj; only consulted while idle.
    always_comb begin
        win_id    = SLOT_CHAR;
        win_taddr = TADDR_W'(char_addr);
        win_saddr = CHAR_OFFSET + AW'(char_addr);
        if (!char_miss && scr_miss) begin
            win_id    = SLOT_SCR;
            win_taddr = TADDR_W'(scr_addr);
            win_saddr = SCR_OFFSET + AW'(scr_addr);
        end else if (!char_miss && !scr_miss) begin
            win_id    = SLOT_OBJ;
            win_taddr = obj_addr;
            win_saddr = OBJ_OFFSET + AW'(obj_addr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q         <= IDLE;
            id_q         <= SLOT_CHAR;
            taddr_q      <= '0;
            sdram_addr_q <= '0;
            req_q        <= 1'b0;
        end else begin
            case (st_q)
                IDLE: begin
                    if (char_miss || scr_miss || obj_miss) begin
                        id_q         <= win_id;
                        taddr_q      <= win_taddr;
                        sdram_addr_q <= win_saddr;
                        req_q        <= 1'b1;
                        st_q         <= REQ;
                    end
                end
                REQ: begin
                    // A rdy coincident with ack completes the transfer at once.
                    if (sdram_ack) begin
                        req_q <= 1'b0;
                        st_q  <= sdram_rdy ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (sdram_rdy) begin
                        st_q <= IDLE;
                    end
                end
                default: begin
                    req_q <= 1'b0;
                    st_q  <= IDLE;
                end
            endcase
        end
    end

    // Data lands under the latched address, never the port's current one.
    assign done    = sdram_rdy && ((st_q == WAIT) || (st_q == REQ && sdram_ack));
    assign we_char = done && (id_q == SLOT_CHAR);
    assign we_scr  = done && (id_q == SLOT_SCR);
    assign we_obj  = done && (id_q == SLOT_OBJ);

    jtkunio_rom_slot #(.SW(14)) u_char (
        .clk     (clk),
        .rst     (rst),
        .en_i    (1'b1),
        .addr_i  (char_addr),
        .we_i    (we_char),
        .waddr_i (taddr_q[13:0]),
        .wdata_i (sdram_dout),
        .data_o  (char_data),
        .ok_o    (char_ok),
        .miss_o  (char_miss)
    );

    jtkunio_rom_slot #(.SW(17)) u_scr (
        .clk     (clk),
        .rst     (rst),
        .en_i    (1'b1),
        .addr_i  (scr_addr),
        .we_i    (we_scr),
        .waddr_i (taddr_q[16:0]),
        .wdata_i (sdram_dout),
        .data_o  (scr_data),
        .ok_o    (scr_ok),
        .miss_o  (scr_miss)
    );

    jtkunio_rom_slot #(.SW(18)) u_obj (
        .clk     (clk),
        .rst     (rst),
        .en_i    (obj_cs),
        .addr_i  (obj_addr),
        .we_i    (we_obj),
        .waddr_i (taddr_q),
        .wdata_i (sdram_dout),
        .data_o  (obj_data),
        .ok_o    (obj_ok),
        .miss_o  (obj_miss)
    );

    assign sdram_addr = sdram_addr_q;
    assign sdram_req  = req_q;

endmodule

// File: tb/tb_jtkunio_rom_server.sv
// Bench for the Kunio ROM server: directed scenarios plus a randomized run
// against a bus-observing cache model and an address-hashed memory.
module tb_jtkunio_rom_server;

    localparam logic [21:0] OFS_CHAR = 22'h00000;
    localparam logic [21:0] OFS_SCR  = 22'h04000;
    localparam logic [21:0] OFS_OBJ  = 22'h24000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] char_addr = 14'h0010;
    logic [16:0] scr_addr  = 17'h00001;
    logic        obj_cs    = 1'b1;
    logic [17:0] obj_addr  = 18'h00002;
    logic [31:0] char_data, scr_data, obj_data;
    logic        char_ok, scr_ok, obj_ok;
    logic [21:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack  = 1'b0;
    logic        sdram_rdy  = 1'b0;
    logic [31:0] sdram_dout = '0;

    always #5 clk = ~clk;

    jtkunio_rom_server dut (
        .clk(clk), .rst(rst),
        .char_addr(char_addr), .char_data(char_data), .char_ok(char_ok),
        .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
        .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
        .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
        .sdram_rdy(sdram_rdy), .sdram_dout(sdram_dout)
    );

    int n_chk  = 0;
    int n_pass = 0;

    bit          resp_en  = 1'b0;
    logic        man_ack  = 1'b0;
    logic        man_rdy  = 1'b0;
    logic [31:0] man_dout = '0;

    logic [13:0] pool_c [4] = '{14'h0000, 14'h0001, 14'h3FFF, 14'h1234};
    logic [16:0] pool_s [4] = '{17'h00000, 17'h00007, 17'h1FFFF, 17'h0ABCD};
    logic [17:0] pool_o [4] = '{18'h00000, 18'h00009, 18'h3FFFF, 18'h2F00F};

    function automatic logic [31:0] mem(input logic [21:0] a);
        return {a[9:0], a} ^ 32'hA5C3_0F96;
    endfunction

    // Memory responder: replays manual pulses, or serves requests with random timing.
    int          r_ph  = 0;
    int          r_cnt = 0;
    logic [21:0] r_a   = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (!resp_en) begin
                sdram_ack  = man_ack;
                sdram_rdy  = man_rdy;
                sdram_dout = man_dout;
                r_ph       = 0;
            end else begin
                sdram_ack = 1'b0;
                sdram_rdy = 1'b0;
                if (rst) begin
                    r_ph = 0;
                end else if (r_ph == 0) begin
                    if (sdram_req) begin
                        r_cnt = $urandom_range(0, 3);
                        r_ph  = 1;
                    end
                end else if (r_ph == 1) begin
                    if (r_cnt == 0) begin
                        sdram_ack = 1'b1;
                        r_a       = sdram_addr;
                        if ($urandom_range(0, 3) == 0) begin
                            sdram_rdy  = 1'b1;
                            sdram_dout = mem(r_a);
                            r_ph       = 0;
                        end else begin
                            r_cnt = $urandom_range(0, 4);
                            r_ph  = 2;
                        end
                    end else begin
                        r_cnt--;
                    end
                end else begin
                    if (r_cnt == 0) begin
                        sdram_rdy  = 1'b1;
                        sdram_dout = mem(r_a);
                        r_ph       = 0;
                    end else begin
                        r_cnt--;
                    end
                end
            end
        end
    end

    // Reference cache: what each port should hold, derived only from bus traffic.
    logic        m_valid [3];
    logic [17:0] m_caddr [3];
    logic [31:0] m_data  [3];
    logic        m_out = 1'b0;
    logic [21:0] m_addr = '0;
    always @(posedge clk) begin
        int          s;
        logic [17:0] l;
        logic [21:0] ca;
        bit          c;
        c  = 1'b0;
        ca = m_addr;
        s  = 0;
        l  = '0;
        if (rst) begin
            m_out <= 1'b0;
            for (int i = 0; i < 3; i++) m_valid[i] <= 1'b0;
        end else if (sdram_req && sdram_ack) begin
            if (sdram_rdy) begin
                c  = 1'b1;
                ca = sdram_addr;
            end else begin
                m_out  <= 1'b1;
                m_addr <= sdram_addr;
            end
        end else if (m_out && sdram_rdy) begin
            c     = 1'b1;
            m_out <= 1'b0;
        end
        if (c) begin
            if (ca < OFS_SCR) begin
                s = 0; l = 18'(ca - OFS_CHAR);
            end else if (ca < OFS_OBJ) begin
                s = 1; l = 18'(ca - OFS_SCR);
            end else begin
                s = 2; l = 18'(ca - OFS_OBJ);
            end
            m_valid[s] <= 1'b1;
            m_caddr[s] <= l;
            m_data[s]  <= sdram_dout;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst     = 1'b1;
        man_ack = 1'b0;
        man_rdy = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Bus driver only: waits for a request, acks it, returns data after lat cycles.
    task automatic handshake(input logic [31:0] d, input int lat,
                             output logic [21:0] a, output bit to);
        int n;
        n  = 0;
        to = 1'b0;
        a  = '0;
        while (sdram_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (sdram_req !== 1'b1) begin
            to = 1'b1;
        end else begin
            a = sdram_addr;
            man_ack = 1'b1; tick(); man_ack = 1'b0;
            repeat (lat) tick();
            man_rdy = 1'b1; man_dout = d; tick(); man_rdy = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_chk++; if ({char_ok, scr_ok, obj_ok, sdram_req} !== 4'b0000)
            $display("FAIL reset_ctrl got=%b exp=0000", {char_ok, scr_ok, obj_ok, sdram_req}); else n_pass++;
        n_chk++; if ({char_data, scr_data, obj_data} !== 96'h0)
            $display("FAIL reset_data got=%h exp=0", {char_data, scr_data, obj_data}); else n_pass++;
        n_chk++; if (sdram_addr !== 22'h0)
            $display("FAIL reset_addr got=%h exp=000000", sdram_addr); else n_pass++;
    endtask

    task automatic test_single_char();
        rst = 1'b0;
        tick();
        n_chk++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h00010)
            $display("FAIL single_req got=%b/%h exp=1/000010", sdram_req, sdram_addr); else n_pass++;
        man_ack = 1'b1; tick(); man_ack = 1'b0;
        n_chk++; if (sdram_req !== 1'b0 || char_ok !== 1'b0)
            $display("FAIL single_wait got=%b/%b exp=0/0", sdram_req, char_ok); else n_pass++;
        man_rdy = 1'b1; man_dout = 32'hDEADBEEF; tick(); man_rdy = 1'b0;
        n_chk++; if (char_ok !== 1'b1 || char_data !== 32'hDEADBEEF)
            $display("FAIL single_ok got=%b/%h exp=1/deadbeef", char_ok, char_data); else n_pass++;
    endtask

    task automatic test_priority();
        logic [21:0] a;
        bit          to;
        tick();
        n_chk++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h04001)
            $display("FAIL prio_scr_req got=%b/%h exp=1/004001", sdram_req, sdram_addr); else n_pass++;
        handshake(32'h5C000001, 1, a, to);
        n_chk++; if (to || a !== 22'h04001)
            $display("FAIL prio_scr_addr got=%h to=%0d exp=004001", a, to); else n_pass++;
        n_chk++; if (scr_ok !== 1'b1 || scr_data !== 32'h5C000001 || char_ok !== 1'b1)
            $display("FAIL prio_scr_ok got=%b/%h/%b exp=1/5c000001/1", scr_ok, scr_data, char_ok); else n_pass++;
        handshake(32'h0B000002, 0, a, to);
        n_chk++; if (to || a !== 22'h24002)
            $display("FAIL prio_obj_addr got=%h to=%0d exp=024002", a, to); else n_pass++;
        n_chk++; if (obj_ok !== 1'b1 || obj_data !== 32'h0B000002)
            $display("FAIL prio_obj_ok got=%b/%h exp=1/0b000002", obj_ok, obj_data); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if (sdram_req !== 1'b0)
                $display("FAIL prio_quiet cyc=%0d got=%b exp=0", i, sdram_req); else n_pass++;
        end
    endtask

    task automatic test_midchange();
        char_addr = 14'h0010;
        apply_reset();
        tick();
        n_chk++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h00010)
            $display("FAIL mid_req1 got=%b/%h exp=1/000010", sdram_req, sdram_addr); else n_pass++;
        man_ack = 1'b1; tick(); man_ack = 1'b0;
        char_addr = 14'h0011;
        man_rdy = 1'b1; man_dout = 32'h1111_0010; tick(); man_rdy = 1'b0;
        n_chk++; if (char_ok !== 1'b0 || char_data !== 32'h1111_0010)
            $display("FAIL mid_stale got=%b/%h exp=0/11110010", char_ok, char_data); else n_pass++;
        tick();
        n_chk++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h00011)
            $display("FAIL mid_req2 got=%b/%h exp=1/000011", sdram_req, sdram_addr); else n_pass++;
        man_ack = 1'b1; tick(); man_ack = 1'b0;
        man_rdy = 1'b1; man_dout = 32'h2222_0011; tick(); man_rdy = 1'b0;
        n_chk++; if (char_ok !== 1'b1 || char_data !== 32'h2222_0011)
            $display("FAIL mid_ok got=%b/%h exp=1/22220011", char_ok, char_data); else n_pass++;
        char_addr = 14'h0010;
        #1;
        n_chk++; if (char_ok !== 1'b0)
            $display("FAIL mid_oldaddr got=%b exp=0", char_ok); else n_pass++;
    endtask

    task automatic test_obj_cs();
        logic [21:0] a;
        bit          to;
        obj_cs = 1'b0; obj_addr = 18'h00003; char_addr = 14'h0010; scr_addr = 17'h00001;
        apply_reset();
        handshake(32'hC0000010, 0, a, to);
        handshake(32'h50000001, 2, a, to);
        n_chk++; if (to || a !== 22'h04001 || char_ok !== 1'b1 || scr_ok !== 1'b1)
            $display("FAIL cs_fill got=%h to=%0d ok=%b%b exp=004001 ok=11", a, to, char_ok, scr_ok); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++; if (sdram_req !== 1'b0 || obj_ok !== 1'b0)
                $display("FAIL cs_idle cyc=%0d got=%b/%b exp=0/0", i, sdram_req, obj_ok); else n_pass++;
        end
        obj_cs = 1'b1;
        #1;
        n_chk++; if (obj_ok !== 1'b0)
            $display("FAIL cs_miss got=%b exp=0", obj_ok); else n_pass++;
        handshake(32'h0B000003, 1, a, to);
        n_chk++; if (to || a !== 22'h24003 || obj_ok !== 1'b1 || obj_data !== 32'h0B000003)
            $display("FAIL cs_fill_obj got=%h/%b/%h exp=024003/1/0b000003", a, obj_ok, obj_data); else n_pass++;
        obj_cs = 1'b0;
        #1;
        n_chk++; if (obj_ok !== 1'b0 || obj_data !== 32'h0B000003)
            $display("FAIL cs_drop got=%b/%h exp=0/0b000003", obj_ok, obj_data); else n_pass++;
        obj_cs = 1'b1;
        #1;
        n_chk++; if (obj_ok !== 1'b1)
            $display("FAIL cs_raise got=%b exp=1", obj_ok); else n_pass++;
        tick();
        n_chk++; if (sdram_req !== 1'b0)
            $display("FAIL cs_noreq got=%b exp=0", sdram_req); else n_pass++;
        obj_addr = 18'h00004;
        tick();
        n_chk++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h24004)
            $display("FAIL cs_req4 got=%b/%h exp=1/024004", sdram_req, sdram_addr); else n_pass++;
        obj_cs = 1'b0;
        man_ack = 1'b1; tick(); man_ack = 1'b0;
        man_rdy = 1'b1; man_dout = 32'h0B000004; tick(); man_rdy = 1'b0;
        n_chk++; if (obj_ok !== 1'b0)
            $display("FAIL cs_gated got=%b exp=0", obj_ok); else n_pass++;
        obj_cs = 1'b1;
        #1;
        n_chk++; if (obj_ok !== 1'b1 || obj_data !== 32'h0B000004)
            $display("FAIL cs_updated got=%b/%h exp=1/0b000004", obj_ok, obj_data); else n_pass++;
    endtask

    task automatic test_coincide();
        logic [21:0] a;
        bit          to;
        char_addr = 14'h0055;
        tick();
        n_chk++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h00055)
            $display("FAIL coin_req got=%b/%h exp=1/000055", sdram_req, sdram_addr); else n_pass++;
        man_ack = 1'b1; man_rdy = 1'b1; man_dout = 32'hC0C0_0055; tick();
        man_ack = 1'b0; man_rdy = 1'b0;
        n_chk++; if (char_ok !== 1'b1 || char_data !== 32'hC0C0_0055 || sdram_req !== 1'b0)
            $display("FAIL coin_ok got=%b/%h/%b exp=1/c0c00055/0", char_ok, char_data, sdram_req); else n_pass++;
        tick();
        n_chk++; if (sdram_req !== 1'b0)
            $display("FAIL coin_extra got=%b exp=0", sdram_req); else n_pass++;
        char_addr = 14'h0056;
        tick();
        n_chk++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h00056)
            $display("FAIL coin_idle got=%b/%h exp=1/000056", sdram_req, sdram_addr); else n_pass++;
        handshake(32'hC0C0_0056, 0, a, to);
        n_chk++; if (to || char_ok !== 1'b1 || char_data !== 32'hC0C0_0056)
            $display("FAIL coin_next got=%b/%h to=%0d exp=1/c0c00056", char_ok, char_data, to); else n_pass++;
    endtask

    task automatic test_reset_mid();
        char_addr = 14'h0077;
        tick();
        n_chk++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h00077)
            $display("FAIL rmid_req got=%b/%h exp=1/000077", sdram_req, sdram_addr); else n_pass++;
        man_ack = 1'b1; tick(); man_ack = 1'b0;
        rst = 1'b1;
        tick();
        n_chk++; if ({char_ok, scr_ok, obj_ok, sdram_req} !== 4'b0000)
            $display("FAIL rmid_clear got=%b exp=0000", {char_ok, scr_ok, obj_ok, sdram_req}); else n_pass++;
        rst = 1'b0;
        man_rdy = 1'b1; man_dout = 32'hDEAD_0077; tick(); man_rdy = 1'b0;
        n_chk++; if (char_ok !== 1'b0 || char_data !== 32'h0)
            $display("FAIL rmid_stray got=%b/%h exp=0/00000000", char_ok, char_data); else n_pass++;
        n_chk++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h00077)
            $display("FAIL rmid_rereq got=%b/%h exp=1/000077", sdram_req, sdram_addr); else n_pass++;
        man_rdy = 1'b1; tick(); man_rdy = 1'b0;
        n_chk++; if (char_ok !== 1'b0 || sdram_req !== 1'b1)
            $display("FAIL rmid_rdy_in_req got=%b/%b exp=0/1", char_ok, sdram_req); else n_pass++;
    endtask

    task automatic test_random();
        int   hc, hs, ho, n;
        logic e;
        hc = 0; hs = 0; ho = 0;
        apply_reset();
        resp_en = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (hc == 0) begin char_addr = pool_c[$urandom_range(0, 3)]; hc = $urandom_range(4, 12); end else hc--;
            if (hs == 0) begin scr_addr  = pool_s[$urandom_range(0, 3)]; hs = $urandom_range(4, 12); end else hs--;
            if (ho == 0) begin obj_addr  = pool_o[$urandom_range(0, 3)]; ho = $urandom_range(4, 12); end else ho--;
            if ($urandom_range(0, 15) == 0) obj_cs = ~obj_cs;
            #1;
            e = m_valid[0] && (m_caddr[0][13:0] == char_addr);
            n_chk++; if (char_ok !== e)
                $display("FAIL rnd_char_ok cyc=%0d got=%b exp=%b", cyc, char_ok, e); else n_pass++;
            if (e) begin
                n_chk++; if (char_data !== mem(OFS_CHAR + 22'(char_addr)))
                    $display("FAIL rnd_char_data cyc=%0d got=%h exp=%h", cyc, char_data, mem(OFS_CHAR + 22'(char_addr))); else n_pass++;
            end
            e = m_valid[1] && (m_caddr[1][16:0] == scr_addr);
            n_chk++; if (scr_ok !== e)
                $display("FAIL rnd_scr_ok cyc=%0d got=%b exp=%b", cyc, scr_ok, e); else n_pass++;
            if (e) begin
                n_chk++; if (scr_data !== mem(OFS_SCR + 22'(scr_addr)))
                    $display("FAIL rnd_scr_data cyc=%0d got=%h exp=%h", cyc, scr_data, mem(OFS_SCR + 22'(scr_addr))); else n_pass++;
            end
            e = obj_cs && m_valid[2] && (m_caddr[2] == obj_addr);
            n_chk++; if (obj_ok !== e)
                $display("FAIL rnd_obj_ok cyc=%0d got=%b exp=%b", cyc, obj_ok, e); else n_pass++;
            if (e) begin
                n_chk++; if (obj_data !== mem(OFS_OBJ + 22'(obj_addr)))
                    $display("FAIL rnd_obj_data cyc=%0d got=%h exp=%h", cyc, obj_data, mem(OFS_OBJ + 22'(obj_addr))); else n_pass++;
            end
        end
        // Steady addresses must all be served within a bounded time.
        obj_cs = 1'b1;
        n = 0;
        while (!(char_ok && scr_ok && obj_ok) && n < 80) begin
            tick();
            n++;
        end
        n_chk++; if ({char_ok, scr_ok, obj_ok} !== 3'b111)
            $display("FAIL rnd_settle got=%b exp=111 after %0d cycles", {char_ok, scr_ok, obj_ok}, n); else n_pass++;
        resp_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_priority();
        test_midchange();
        test_obj_cs();
        test_coincide();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
